// File: rtl/vector_pkg.sv
// Shared vector-display definitions: list-word layout, opcodes and field helpers.
package vector_pkg;

  localparam int COORD_W = 12;
  localparam int WORD_W  = 26;
  localparam int OP_LSB  = 24;
  localparam int Y_LSB   = 12;
  localparam int X_LSB   = 0;

  localparam logic [1:0] OP_JUMP = 2'b00;
  localparam logic [1:0] OP_DRAW = 2'b01;
  localparam logic [1:0] OP_END  = 2'b10;
  localparam logic [1:0] OP_NOP  = 2'b11;

  function automatic logic [1:0] word_op(input logic [WORD_W-1:0] w);
    return w[OP_LSB +: 2];
  endfunction

  function automatic logic [COORD_W-1:0] word_x(input logic [WORD_W-1:0] w);
    return w[X_LSB +: COORD_W];
  endfunction

  function automatic logic [COORD_W-1:0] word_y(input logic [WORD_W-1:0] w);
    return w[Y_LSB +: COORD_W];
  endfunction

endpackage

// File: rtl/display_list_player.sv
// Walks a vector display list from sync RAM, hands JUMP/DRAW commands to the
// draw controller under ready handshake, and replays the frame on each refresh tick.
//
//   state      | meaning
//   IDLE       | stopped, waiting for enable
//   FETCH      | read request for the current address
//   DATA       | list word arrives, latch and decode
//   ISSUE      | waiting for controller ready, then pulse jump/draw
//   HOLD       | ready ignored for HOLDOFF cycles after a pulse
//   FRAME_WAIT | frame finished, waiting for the refresh tick
module display_list_player
  import vector_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int HOLDOFF = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               frame_tick,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_rd,
  input  logic [WORD_W-1:0]  mem_data,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               jump,
  output logic               draw,
  input  logic               ready,
  output logic               busy,
  output logic               frame_done,
  output logic               frame_late
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DATA,
    S_ISSUE,
    S_HOLD,
    S_FRAME_WAIT
  } state_t;

  localparam int CNT_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLDOFF - 1);

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   addr;
  logic                wrapped;
  logic [WORD_W-1:0]   cmd;
  logic [CNT_W-1:0]    hold_cnt;
  logic                tick_pending;
  logic [COORD_W-1:0]  x_hold, y_hold;
  logic [1:0]          fetched_op;
  logic                accept;

  always_comb begin
    // once the address has rolled past the last word, the next fetch is a synthetic END
    fetched_op = wrapped ? OP_END : word_op(mem_data);
    accept     = (state == S_ISSUE) && ready;
    state_nxt  = state;
    case (state)
      S_IDLE:  if (enable) state_nxt = S_FETCH;
      S_FETCH: state_nxt = S_DATA;
      S_DATA: begin
        case (fetched_op)
          OP_JUMP, OP_DRAW: state_nxt = S_ISSUE;
          OP_END:           state_nxt = enable ? S_FRAME_WAIT : S_IDLE;
          default:          state_nxt = enable ? S_FETCH : S_IDLE;
        endcase
      end
      S_ISSUE: if (ready) state_nxt = S_HOLD;
      S_HOLD:  if (hold_cnt == '0) state_nxt = enable ? S_FETCH : S_IDLE;
      S_FRAME_WAIT: begin
        if (!enable)           state_nxt = S_IDLE;
        else if (tick_pending) state_nxt = S_FETCH;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr       <= '0;
      wrapped    <= 1'b0;
      cmd        <= '0;
      hold_cnt   <= '0;
      x_hold     <= '0;
      y_hold     <= '0;
      frame_done <= 1'b0;
      frame_late <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      frame_late <= 1'b0;
      case (state)
        S_IDLE: begin
          if (enable) begin
            addr    <= '0;
            wrapped <= 1'b0;
          end
        end
        S_DATA: begin
          cmd <= mem_data;
          if (fetched_op == OP_END) begin
            frame_done <= 1'b1;
            frame_late <= tick_pending | frame_tick;
            addr       <= '0;
            wrapped    <= 1'b0;
          end else if (fetched_op == OP_NOP) begin
            addr    <= addr + 1'b1;
            wrapped <= (addr == '1);
          end
        end
        S_ISSUE: begin
          if (ready) begin
            x_hold   <= word_x(cmd);
            y_hold   <= word_y(cmd);
            addr     <= addr + 1'b1;
            wrapped  <= (addr == '1);
            hold_cnt <= HOLD_LOAD;
          end
        end
        S_HOLD: if (hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
        S_FRAME_WAIT: if (enable && tick_pending) addr <= '0;
        default: ;
      endcase
    end
  end

  // a tick arriving in the same cycle it is consumed is kept for the next frame
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                           tick_pending <= 1'b0;
    else if (state == S_IDLE && enable)                  tick_pending <= 1'b0;
    else if (state == S_FRAME_WAIT && enable && tick_pending) tick_pending <= frame_tick;
    else if (frame_tick)                                 tick_pending <= 1'b1;
  end

  assign mem_addr = addr;
  assign mem_rd   = (state == S_FETCH) && !wrapped;
  assign busy     = (state != S_IDLE);
  assign jump     = accept && (word_op(cmd) == OP_JUMP);
  assign draw     = accept && (word_op(cmd) == OP_DRAW);
  assign x        = accept ? word_x(cmd) : x_hold;
  assign y        = accept ? word_y(cmd) : y_hold;

endmodule

// File: tb/tb_display_list_player.sv
// Bench for display_list_player: directed frames plus randomized lists, ready
// patterns and late ticks, checked against an expected-command walk of the list.
module tb_display_list_player;
  import vector_pkg::*;

  localparam int ADDR_W  = 4;
  localparam int HOLDOFF = 2;
  localparam int DEPTH   = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              enable = 1'b0;
  logic              frame_tick = 1'b0;
  logic              ready = 1'b1;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [25:0]       mem_data = '0;
  logic [11:0]       x, y;
  logic              jump, draw, busy, frame_done, frame_late;

  always #5 clk = ~clk;

  display_list_player #(.ADDR_W(ADDR_W), .HOLDOFF(HOLDOFF)) dut (
    .clk(clk), .reset(reset), .enable(enable), .frame_tick(frame_tick),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
    .x(x), .y(y), .jump(jump), .draw(draw), .ready(ready),
    .busy(busy), .frame_done(frame_done), .frame_late(frame_late)
  );

  logic [25:0] mem [DEPTH];
  always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr];

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [11:0] px;
    logic [11:0] py;
    int          cyc;
  } pulse_t;

  pulse_t pq[$];
  pulse_t exp_q[$];
  pulse_t mon_p;

  int cyc = 0, rd_cnt = 0, rd_cyc = 0, fd_cnt = 0, fd_cyc = 0, fd_gap = 0;
  logic [ADDR_W-1:0] rd_addr = '0, fd_addr = '0;
  logic late_seen = 1'b0;
  logic [11:0] last_x = '0, last_y = '0;

  // monitor: records pulses, reads and frame ends; checks interface invariants
  always @(negedge clk) begin
    if (reset) begin
      last_x = '0;
      last_y = '0;
    end else begin
      cyc++;
      if (jump || draw) begin
        mon_p.op  = jump ? 2'b00 : 2'b01;
        mon_p.px  = x;
        mon_p.py  = y;
        mon_p.cyc = cyc;
        pq.push_back(mon_p);
        check("pulse_while_ready", 32'(ready), 32'd1);
        check("jump_draw_excl", 32'(jump & draw), 32'd0);
        last_x = x;
        last_y = y;
      end else if (x !== last_x || y !== last_y) begin
        check("xy_hold", 32'({x, y}), 32'({last_x, last_y}));
        last_x = x;
        last_y = y;
      end
      if (mem_rd) begin
        rd_cnt++;
        rd_cyc  = cyc;
        rd_addr = mem_addr;
      end
      if (frame_done) begin
        fd_cnt++;
        fd_gap    = cyc - rd_cyc;
        fd_cyc    = cyc;
        fd_addr   = mem_addr;
        late_seen = frame_late;
      end else begin
        check("late_without_done", 32'(frame_late), 32'd0);
      end
    end
  end

  int   rdy_mode  = 0;
  logic ready_man = 1'b0;
  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       ready = 1'b1;
      1:       ready = ($urandom_range(0, 3) != 0);
      default: ready = ready_man;
    endcase
  end

  function automatic logic [25:0] w(input logic [1:0] op, input int xx, input int yy);
    return {op, yy[11:0], xx[11:0]};
  endfunction

  // reference: the commands a frame should issue, walking from address 0 to END or list end
  function automatic void build_expected();
    pulse_t p;
    exp_q.delete();
    for (int a = 0; a < DEPTH; a++) begin
      if (mem[a][25:24] == 2'b10) break;
      if (mem[a][25:24] == 2'b00 || mem[a][25:24] == 2'b01) begin
        p.op  = mem[a][25:24];
        p.px  = mem[a][11:0];
        p.py  = mem[a][23:12];
        p.cyc = 0;
        exp_q.push_back(p);
      end
    end
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic compare_pulses(input string tag);
    check({tag, "_count"}, 32'(pq.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < pq.size(); i++) begin
      check({tag, "_op"}, 32'(pq[i].op), 32'(exp_q[i].op));
      check({tag, "_x"},  32'(pq[i].px), 32'(exp_q[i].px));
      check({tag, "_y"},  32'(pq[i].py), 32'(exp_q[i].py));
    end
  endtask

  task automatic wait_frame(input int n0, input int budget);
    int k = 0;
    while (fd_cnt == n0 && k < budget) begin
      step(1);
      k++;
    end
    check("frame_done_seen", 32'(fd_cnt - n0), 32'd1);
  endtask

  task automatic wait_read(input int n0, input int budget);
    int k = 0;
    while (rd_cnt == n0 && k < budget) begin
      step(1);
      k++;
    end
    check("read_seen", 32'(rd_cnt != n0), 32'd1);
  endtask

  task automatic start();
    pq.delete();
    @(posedge clk);
    #1 enable = 1'b1;
  endtask

  task automatic go_idle();
    int k = 0;
    @(posedge clk);
    #1 enable = 1'b0;
    while (busy && k < 400) begin
      step(1);
      k++;
    end
    check("idle_reached", 32'(busy), 32'd0);
  endtask

  task automatic check_zero_outs(input string tag);
    check({tag, "_mem_addr"},   32'(mem_addr),   32'd0);
    check({tag, "_mem_rd"},     32'(mem_rd),     32'd0);
    check({tag, "_x"},          32'(x),          32'd0);
    check({tag, "_y"},          32'(y),          32'd0);
    check({tag, "_jump"},       32'(jump),       32'd0);
    check({tag, "_draw"},       32'(draw),       32'd0);
    check({tag, "_busy"},       32'(busy),       32'd0);
    check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    check({tag, "_frame_late"}, 32'(frame_late), 32'd0);
  endtask

  initial begin
    int n0, r0, k, late, len;
    logic [1:0] op;

    for (int a = 0; a < DEPTH; a++) mem[a] = w(2'b10, 0, 0);
    repeat (3) @(posedge clk);
    #1 check_zero_outs("reset");
    @(negedge clk) reset = 1'b0;
    step(2);
    check_zero_outs("after_reset");

    // basic frame: JUMP, DRAW, END with ready tied high, then tick-driven replay
    mem[0] = w(2'b00, 100, 200);
    mem[1] = w(2'b01, 4095, 0);
    mem[2] = w(2'b10, 0, 0);
    rdy_mode = 0;
    build_expected();
    n0 = fd_cnt;
    start();
    wait_frame(n0, 100);
    compare_pulses("basic");
    if (pq.size() >= 2) check("basic_period", 32'(pq[1].cyc - pq[0].cyc), 32'(3 + HOLDOFF));
    check("basic_done_gap", 32'(fd_gap), 32'd2);
    check("basic_not_late", 32'(late_seen), 32'd0);
    r0 = rd_cnt;
    step(30);
    check("basic_no_fetch_before_tick", 32'(rd_cnt - r0), 32'd0);
    check("basic_busy_waiting", 32'(busy), 32'd1);
    pq.delete();
    n0 = fd_cnt;
    @(posedge clk);
    #1 frame_tick = 1'b1;
    @(posedge clk);
    #1 frame_tick = 1'b0;
    wait_read(r0, 10);
    check("replay_addr0", 32'(rd_addr), 32'd0);
    wait_frame(n0, 100);
    compare_pulses("replay");
    check("replay_not_late", 32'(late_seen), 32'd0);
    go_idle();

    // ready stalled for 50 cycles in ISSUE
    mem[0] = w(2'b00, 11, 22);
    mem[1] = w(2'b10, 0, 0);
    rdy_mode  = 2;
    ready_man = 1'b0;
    r0 = rd_cnt;
    start();
    wait_read(r0, 10);
    step(52);
    check("stall_no_pulse", 32'(pq.size()), 32'd0);
    check("stall_x_held", 32'(x), 32'd4095);
    check("stall_y_held", 32'(y), 32'd0);
    ready_man = 1'b1;
    step(1);
    check("stall_pulse_count", 32'(pq.size()), 32'd1);
    if (pq.size() > 0) begin
      check("stall_pulse_first_ready", 32'(pq[0].cyc), 32'(cyc));
      check("stall_pulse_x", 32'(pq[0].px), 32'd11);
      check("stall_pulse_y", 32'(pq[0].py), 32'd22);
    end
    rdy_mode = 0;
    step(10);
    go_idle();

    // NOPs interleaved
    mem[0] = w(2'b11, 1, 1);
    mem[1] = w(2'b11, 2, 2);
    mem[2] = w(2'b01, 7, 7);
    mem[3] = w(2'b10, 0, 0);
    build_expected();
    n0 = fd_cnt;
    start();
    wait_frame(n0, 100);
    compare_pulses("nop");
    go_idle();

    // no END in the list: address wraps and the frame ends without a 17th read
    for (int a = 0; a < DEPTH; a++) mem[a] = w(2'b01, $urandom_range(0, 4095), $urandom_range(0, 4095));
    build_expected();
    n0 = fd_cnt;
    r0 = rd_cnt;
    start();
    wait_frame(n0, 400);
    compare_pulses("wrap");
    check("wrap_reads", 32'(rd_cnt - r0), 32'(DEPTH));
    check("wrap_addr_at_done", 32'(fd_addr), 32'd0);
    check("wrap_addr_now", 32'(mem_addr), 32'd0);
    go_idle();

    // randomized lists, ready patterns and late ticks
    for (int it = 0; it < 12; it++) begin
      len = $urandom_range(0, 8);
      for (int a = 0; a < DEPTH; a++) mem[a] = 26'($urandom);
      for (int a = 0; a < len; a++) begin
        k  = $urandom_range(0, 2);
        op = (k == 0) ? 2'b00 : (k == 1) ? 2'b01 : 2'b11;
        mem[a] = w(op, $urandom_range(0, 4095), $urandom_range(0, 4095));
      end
      mem[len] = w(2'b10, 0, 0);
      late = $urandom_range(0, 1);
      rdy_mode = 1;
      build_expected();
      n0 = fd_cnt;
      start();
      if (late != 0) begin
        @(posedge clk);
        @(posedge clk);
        #1 frame_tick = 1'b1;
        @(posedge clk);
        #1 frame_tick = 1'b0;
      end
      wait_frame(n0, 600);
      compare_pulses("rand");
      check("rand_done_gap", 32'(fd_gap), 32'd2);
      check("rand_late", 32'(late_seen), 32'(late));
      r0 = rd_cnt;
      if (late != 0) begin
        wait_read(r0, 10);
        check("rand_replay_addr0", 32'(rd_addr), 32'd0);
        check("rand_replay_gap", 32'(rd_cyc - fd_cyc), 32'd1);
      end else begin
        step(20);
        check("rand_no_fetch", 32'(rd_cnt - r0), 32'd0);
      end
      go_idle();
    end

    // enable dropped during DATA of a DRAW
    rdy_mode = 0;
    mem[0] = w(2'b01, 300, 400);
    mem[1] = w(2'b01, 5, 5);
    mem[2] = w(2'b10, 0, 0);
    r0 = rd_cnt;
    start();
    @(posedge clk);
    @(posedge clk);
    #1 enable = 1'b0;
    k = 0;
    while (pq.size() == 0 && k < 20) begin
      step(1);
      k++;
    end
    check("stop_pulse_count", 32'(pq.size()), 32'd1);
    if (pq.size() > 0) check("stop_pulse_x", 32'(pq[0].px), 32'd300);
    k = 0;
    while (busy && k < 20) begin
      step(1);
      k++;
    end
    check("stop_busy_fall", 32'(k), 32'(HOLDOFF + 1));
    step(5);
    check("stop_no_more_pulses", 32'(pq.size()), 32'd1);
    check("stop_one_read", 32'(rd_cnt - r0), 32'd1);

    // asynchronous reset while in HOLD
    mem[0] = w(2'b01, 5, 6);
    mem[1] = w(2'b01, 9, 9);
    mem[2] = w(2'b10, 0, 0);
    start();
    k = 0;
    while (pq.size() == 0 && k < 20) begin
      step(1);
      k++;
    end
    check("hold_pulse_seen", 32'(pq.size()), 32'd1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1 check_zero_outs("async_reset");
    enable = 1'b0;
    #4 reset = 1'b0;
    step(3);
    check_zero_outs("post_reset_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/display_list_player.md
# display_list_player

Sequencer that reads a vector display list from synchronous RAM and feeds the vector draw controller one command at a time over its x/y/jump/draw/ready interface. It is the producer end of that interface. It walks the list from address 0, issues each JUMP or DRAW only while the controller reports ready, and stops at END. It then waits for the refresh tick and replays the frame, so the beam keeps redrawing a static picture without CPU involvement.

## Interface
Parameters:
- ADDR_W, 10, display-list address width (list depth 2^ADDR_W words)
- HOLDOFF, 2, cycles after a jump/draw pulse during which ready is ignored (min 1)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  level; 1 = run/replay list, 0 = finish current command then idle
- frame_tick  in  1  one-cycle refresh strobe
- mem_addr  out  ADDR_W  display-list read address
- mem_rd  out  1  read request; mem_data valid exactly one cycle later
- mem_data  in  26  list word: [25:24] opcode, [23:12] y, [11:0] x
- x  out  12  target X, held from issue until next issue
- y  out  12  target Y, held from issue until next issue
- jump  out  1  one-cycle pulse: move beam blanked to (x,y)
- draw  out  1  one-cycle pulse: draw line to (x,y)
- ready  in  1  controller idle and able to accept a command
- busy  out  1  1 in any state other than IDLE
- frame_done  out  1  one-cycle pulse when END is consumed
- frame_late  out  1  one-cycle pulse when the frame finished after its tick had already arrived

## Operation
- Opcodes: 00 JUMP, 01 DRAW, 10 END, 11 NOP.
- The FSM has six states: IDLE, FETCH, DATA, ISSUE, HOLD, FRAME_WAIT.
- IDLE -> FETCH when enable=1. mem_addr=0 on this entry.
- FETCH: assert mem_rd for one cycle, then go to DATA.
- DATA: register mem_data into the command register and decode it.
  - JUMP/DRAW -> ISSUE.
  - NOP -> increment the address, then FETCH.
  - END -> pulse frame_done, then FRAME_WAIT.
- ISSUE: wait for ready=1. In that cycle:
  - load x/y from the command register;
  - pulse jump or draw;
  - increment the address;
  - go to HOLD.
- HOLD: count HOLDOFF cycles. ready is ignored during the count. Then:
  - FETCH if enable=1;
  - IDLE if enable=0.
- FRAME_WAIT: on tick_pending, clear it, set address 0 and go to FETCH. If enable=0, go to IDLE.
- tick_pending flag:
  - set by frame_tick in any state except FRAME_WAIT;
  - also set by frame_tick in FRAME_WAIT, where it is consumed the next cycle;
  - cleared on entry to FETCH from IDLE.
- If tick_pending=1 when END is decoded, pulse frame_late in the same cycle as frame_done. The replay still waits one FRAME_WAIT cycle.
- Address wrap: a JUMP/DRAW/NOP at address 2^ADDR_W-1 is processed normally. The following fetch is then treated as END without a memory read: frame_done pulses and the address returns to 0.
- enable falling in FETCH/DATA/ISSUE: the in-flight word is still completed (issued, or END handled), then the FSM goes to IDLE.
- The address counter is ADDR_W bits, unsigned, and increments by 1.

## Timing
- Reset values: mem_addr=0, mem_rd=0, x=0, y=0, jump=0, draw=0, busy=0, frame_done=0, frame_late=0, state=IDLE, tick_pending=0.
- Async reset mid-command aborts immediately. No pulse completes.
- Memory read latency: mem_rd at cycle n gives mem_data sampled at n+1.
- Best-case command period: FETCH, DATA, ISSUE (with ready=1), then HOLDOFF cycles, giving 3+HOLDOFF cycles.
- x/y change only in the ISSUE cycle. They are registered and valid in the same cycle as the jump/draw pulse.
- jump and draw are never high together, and never high while ready=0.
- frame_done is 2 cycles after END's FETCH. Replay FETCH is no earlier than 1 cycle after frame_done.
- frame_tick coinciding with END decode counts as late.

## Structure
- Shared package vector_pkg holds the opcode constants (OP_JUMP, OP_DRAW, OP_END, OP_NOP), the list-word field positions, and the 12-bit coordinate width. The controller and list-building tools use the same package.
- Single module. The holdoff counter and address counter stay inline; no sub-module is warranted.

## Test plan
- List {JUMP(100,200), DRAW(4095,0), END} with ready tied to 1:
  - jump pulses with x=100, y=200;
  - draw pulses 3+HOLDOFF cycles later with x=4095, y=0;
  - then frame_done;
  - no further fetch until frame_tick.
- ready held 0 for 50 cycles in ISSUE: no pulse, x/y unchanged; the pulse occurs in the first cycle ready=1.
- frame_tick during the second command of a 3-command frame:
  - at END, frame_done and frame_late pulse together;
  - replay starts at address 0 without waiting for another tick.
- ADDR_W=2, list of 4 DRAWs with no END: 4 draws, then frame_done with no 5th mem_rd; mem_addr returns to 0.
- NOPs interleaved: {NOP, NOP, DRAW(7,7), END} produces exactly one draw, with x=7, y=7.
- Stop and reset:
  - enable dropped during DATA of a DRAW: the draw still issues, then busy falls after HOLD.
  - reset asserted in HOLD: all outputs are 0 immediately (asynchronously).
